// File: rtl/stream_rr_arbiter.sv
// N-to-1 round-robin stream arbiter with a single registered output stage.
// Define STREAM_RR_ARB_PKT_LOCK_EN to hold the grant on one requester until its last beat.
module stream_rr_arbiter #(
    parameter int WIDTH = 32,
    parameter int N     = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [N-1:0]           in_valid,
    input  logic [N*WIDTH-1:0]     in_data,
    input  logic [N-1:0]           in_last,
    output logic [N-1:0]           in_ready,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_last,
    output logic [$clog2(N)-1:0]   out_src,
    input  logic                   out_ready
);

    localparam int              PW       = $clog2(N);
    localparam logic [PW:0]     N_EXT    = (PW+1)'(N);
    localparam logic [PW-1:0]   LAST_IDX = PW'(N-1);

    logic [PW-1:0]    ptr;
    logic [N-1:0]     grant;
    logic             space;
    logic             take;
    logic [PW-1:0]    sel;
    logic [WIDTH-1:0] sel_data;
    logic             sel_last;
    logic [PW:0]      pos;
    logic             found;

`ifdef STREAM_RR_ARB_PKT_LOCK_EN
    logic             locked;
    logic [PW-1:0]    lock_idx;
`endif

    // Search upward from ptr; pos never exceeds 2N-2, so one wrap subtraction suffices.
    always_comb begin
        grant = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, ptr} + k[PW:0];
            if (pos >= N_EXT)
                pos = pos - N_EXT;
            if (!found && in_valid[pos[PW-1:0]]) begin
                grant[pos[PW-1:0]] = 1'b1;
                found              = 1'b1;
            end
        end
`ifdef STREAM_RR_ARB_PKT_LOCK_EN
        if (locked) begin
            grant           = '0;
            grant[lock_idx] = in_valid[lock_idx];
        end
`endif
    end

    assign space    = !out_valid || out_ready;
    assign in_ready = space ? grant : '0;
    assign take     = |in_ready;

    always_comb begin
        sel      = '0;
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (in_ready[i]) begin
                sel      = PW'(i);
                sel_data = in_data[i*WIDTH +: WIDTH];
                sel_last = in_last[i];
            end
        end
    end

    // A simultaneous load and drain simply overwrites the beat, keeping out_valid high.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_src   <= '0;
        end else if (take) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_last  <= sel_last;
            out_src   <= sel;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            ptr <= '0;
        else if (take)
            ptr <= (sel == LAST_IDX) ? '0 : sel + 1'b1;
    end

`ifdef STREAM_RR_ARB_PKT_LOCK_EN
    // Lock follows every accepted beat: a non-last beat pins the source, a last beat releases it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            locked   <= 1'b0;
            lock_idx <= '0;
        end else if (take) begin
            locked   <= !sel_last;
            lock_idx <= sel;
        end
    end
`endif

endmodule
